// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the single-master parallel bus and its
// register-file slave: default address/data widths, the address-region
// code that selects the slave, and the slave FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 32;

  // addr[15:12] value that routes a request to the register-file slave
  localparam logic [3:0] BUS_SLAVE_BASE = 4'h0;

  typedef logic [BUS_ADDR_W-1:0] addr_t;
  typedef logic [BUS_DATA_W-1:0] data_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/bus_slave_reg_if.sv
// ---------------------------------------------------------------------------
// bus_slave_reg_if
// Request/response signal bundle of the parallel bus.
// Signals:
//   valid, read, write, addr, write_data : master -> slave request
//   ready, read_data, err                : slave -> master response
// Modports: master (drives the request), slave (drives the response).
// ---------------------------------------------------------------------------
interface bus_slave_reg_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              valid;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              ready;
  logic [DATA_W-1:0] read_data;
  logic              err;

  modport master (
    output valid, read, write, addr, write_data,
    input  ready, read_data, err
  );

  modport slave (
    input  valid, read, write, addr, write_data,
    output ready, read_data, err
  );

endinterface

// File: rtl/bus_slave_reg_reg_array.sv
// ---------------------------------------------------------------------------
// reg_array
// DEPTH x DATA_W register storage, cleared by the asynchronous reset.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, clears every entry
//   we_i     : write enable (synchronous)
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : combinational read data
// ---------------------------------------------------------------------------
module reg_array #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_slave_reg.sv
// ---------------------------------------------------------------------------
// bus_slave_reg
// Memory-mapped register-file slave. Claims the address region whose top
// nibble equals SLAVE_BASE, accepts one request in IDLE, performs the
// register write or captures the read data on the accept edge, then
// presents a one-cycle ready pulse (with err) in RESP.
// Ports:
//   clk   : bus clock
//   rst_n : asynchronous active-low reset (clears registers and outputs)
//   bus   : slave side of the bus (valid/read/write/addr/write_data in,
//           ready/read_data/err out)
// ---------------------------------------------------------------------------
module bus_slave_reg
  import bus_pkg::*;
#(
  parameter int         ADDR_W     = BUS_ADDR_W,
  parameter int         DATA_W     = BUS_DATA_W,
  parameter int         DEPTH      = 16,
  parameter logic [3:0] SLAVE_BASE = BUS_SLAVE_BASE
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_slave_reg_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // 13 bits so DEPTH=4096 still fits when compared against addr[11:0]
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  bus_state_t        state_q, state_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              sel;
  logic              in_range;
  logic              req_err;
  logic              we;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem_rdata;

  assign sel      = (bus.addr[ADDR_W-1 -: 4] == SLAVE_BASE);
  assign in_range = ({1'b0, bus.addr[11:0]} < DEPTH_L);
  assign idx      = bus.addr[IDX_W-1:0];
  // read==write covers both "neither" and "both" qualifiers
  assign req_err  = !sel || !in_range || (bus.read == bus.write);

  reg_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_reg_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (idx),
    .wdata_i (bus.write_data),
    .raddr_i (idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Accept only from IDLE so a request still held during RESP is not
  // taken twice; read_data and err hold their values outside an accept.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = req_err;
          if (!req_err && bus.write) begin
            we = 1'b1;
          end
          if (!req_err && bus.read) begin
            rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_bus_slave_reg.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_reg
// Directed, table-driven bench for bus_slave_reg with hand-written
// sequences for reset abort and back-to-back throughput.
// ---------------------------------------------------------------------------
module tb_bus_slave_reg;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  bus_slave_reg_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  bus_slave_reg #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .DEPTH      (16),
    .SLAVE_BASE (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expData;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drives one request at a falling edge, waits (bounded) for ready, then
  // checks latency, err and read_data, and that ready drops afterwards.
  task automatic applyStimulus(input string name, input logic rd,
                               input logic wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic expErr,
                               input logic [31:0] expData);
    int cycles;
    @(negedge clk);
    bus.valid      = 1'b1;
    bus.read       = rd;
    bus.write      = wr;
    bus.addr       = addr;
    bus.write_data = wdata;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.ready && cycles < 5);
    checkOutput({name, " latency"}, 32'(cycles), 32'd1);
    checkOutput({name, " err"}, {31'd0, bus.err}, {31'd0, expErr});
    checkOutput({name, " read_data"}, bus.read_data, expData);
    @(negedge clk);
    bus.valid = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, " ready drop"}, {31'd0, bus.ready}, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] pat;
    checkCount = 0;
    errorCount = 0;

    vecs[0]  = '{"wr 0003",      1'b0, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{"rd 0003",      1'b1, 1'b0, 16'h0003, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{"wr miss 1003", 1'b0, 1'b1, 16'h1003, 32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{"rd 0003 again",1'b1, 1'b0, 16'h0003, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{"rd oor 0010",  1'b1, 1'b0, 16'h0010, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[5]  = '{"rdwr 0005",    1'b1, 1'b1, 16'h0005, 32'hAAAA5555, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{"rd 0005",      1'b1, 1'b0, 16'h0005, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{"noop 0005",    1'b0, 1'b0, 16'h0005, 32'h11112222, 1'b1, 32'h0};
    vecs[8]  = '{"rd 000F",      1'b1, 1'b0, 16'h000F, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{"wr 000F",      1'b0, 1'b1, 16'h000F, 32'h0F0F0F0F, 1'b0, 32'h0};
    vecs[10] = '{"rd 000F new",  1'b1, 1'b0, 16'h000F, 32'h0,        1'b0, 32'h0F0F0F0F};
    vecs[11] = '{"rd miss 2000", 1'b1, 1'b0, 16'h2000, 32'h0,        1'b1, 32'h0F0F0F0F};
    vecs[12] = '{"wr oor 0FFF",  1'b0, 1'b1, 16'h0FFF, 32'hBAD0BAD0, 1'b1, 32'h0F0F0F0F};
    vecs[13] = '{"rd 000F kept", 1'b1, 1'b0, 16'h000F, 32'h0,        1'b0, 32'h0F0F0F0F};

    bus.valid      = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;
    rst_n          = 1'b1;

    // Asynchronous reset asserted mid-cycle
    #12;
    rst_n = 1'b0;
    #1;
    checkOutput("reset ready", {31'd0, bus.ready}, 32'd0);
    checkOutput("reset err", {31'd0, bus.err}, 32'd0);
    checkOutput("reset read_data", bus.read_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("reset rd %0d", i), 1'b1, 1'b0, 16'(i),
                    32'h0, 1'b0, 32'h0);
    end

    // valid low with write set must not touch anything
    @(negedge clk);
    bus.write      = 1'b1;
    bus.addr       = 16'h0002;
    bus.write_data = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("idle no ready", {31'd0, bus.ready}, 32'd0);
    end
    @(negedge clk);
    bus.write = 1'b0;
    applyStimulus("rd 0002 untouched", 1'b1, 1'b0, 16'h0002, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].expErr, vecs[i].expData);
    end

    // Reset during the RESP cycle of a read aborts it and clears memory
    @(negedge clk);
    bus.valid = 1'b1;
    bus.read  = 1'b1;
    bus.addr  = 16'h0003;
    @(posedge clk);
    #1;
    checkOutput("abort pre ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("abort pre data", bus.read_data, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort ready", {31'd0, bus.ready}, 32'd0);
    checkOutput("abort read_data", bus.read_data, 32'd0);
    bus.valid = 1'b0;
    bus.read  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post abort idle", {31'd0, bus.ready}, 32'd0);
    applyStimulus("rd 0003 cleared", 1'b1, 1'b0, 16'h0003, 32'h0, 1'b0, 32'h0);

    // Back-to-back writes with valid held: ready on every other cycle
    @(negedge clk);
    bus.valid      = 1'b1;
    bus.write      = 1'b1;
    bus.addr       = 16'h0000;
    bus.write_data = 32'h0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b ready c%0d", c), {31'd0, bus.ready},
                  {31'd0, (c % 2 == 0)});
      if (bus.ready) begin
        pulses++;
        @(negedge clk);
        if (pulses < 8) begin
          pat            = 32'h11111111 * 32'(pulses);
          bus.addr       = 16'(pulses);
          bus.write_data = pat;
        end else begin
          bus.valid = 1'b0;
          bus.write = 1'b0;
        end
      end
    end
    checkOutput("b2b pulse count", 32'(pulses), 32'd8);

    for (int i = 0; i < 9; i++) begin
      pat = (i < 8) ? 32'h11111111 * 32'(i) : 32'h0;
      applyStimulus($sformatf("b2b rd %0d", i), 1'b1, 1'b0, 16'(i),
                    32'h0, 1'b0, pat);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
